// File: rtl/memory_to_dram.sv
// memory_to_dram: streams a run of BRAM words as one dense MSB-first bitstream of bytes
// Ports: clk/rst (sync, active-high); start/base_addr/word_count launch a transfer;
//   bram_rd_en/bram_addr/bram_rd_data read BRAM with one-cycle latency;
//   dout_data/dout_valid/dout_ready carry bytes; busy spans the transfer, done pulses at its end.
// Optional: define MEM_TO_DRAM_PREFETCH_EN to add a holding register that hides refill bubbles.
module memory_to_dram #(
    parameter int WORD_W = 163,
    parameter int BYTE_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    output logic              bram_rd_en,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [WORD_W-1:0] bram_rd_data,
    output logic [BYTE_W-1:0] dout_data,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              busy,
    output logic              done
);
    localparam int BUF_W = WORD_W + BYTE_W - 1;
    localparam int PAD = BUF_W - WORD_W;
    localparam int CNT_W = $clog2(BUF_W + 1);
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, SHIFT, FLUSH, DONE} state_t;
    state_t state, state_n;
    logic [BUF_W-1:0] bits, shifted;
    logic [CNT_W-1:0] cnt, cnt_sh;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0] rem;
    logic fire, take, refill;
`ifdef MEM_TO_DRAM_PREFETCH_EN
    localparam state_t MORE = LOAD;
    logic [WORD_W-1:0] hold;
    logic full, pend, issue;
`else
    localparam state_t MORE = FETCH;
`endif

    // Bits are kept left-justified; a new word lands directly below the c residual bits.
    function automatic logic [BUF_W-1:0] place(input logic [WORD_W-1:0] w, input logic [CNT_W-1:0] c);
        return BUF_W'(w) << (CNT_W'(PAD) - c);
    endfunction

    assign fire = dout_valid && dout_ready;
    assign cnt_sh = cnt - CNT_W'(BYTE_W);
    assign take = state == SHIFT && fire && cnt_sh < CNT_W'(BYTE_W);
    assign shifted = bits << BYTE_W;
    assign dout_data = bits[BUF_W-1 -: BYTE_W];
    assign dout_valid = state == SHIFT || state == FLUSH;
    assign bram_addr = addr;
    assign busy = state != IDLE && state != DONE;
    assign done = state == DONE;
`ifdef MEM_TO_DRAM_PREFETCH_EN
    assign issue = state == SHIFT && !full && !pend && rem != '0;
    assign bram_rd_en = state == FETCH || issue;
    // A word is on hand either in the holding register or on the BRAM bus this cycle.
    assign refill = full || pend;
`else
    assign bram_rd_en = state == FETCH;
    assign refill = 1'b0;
`endif

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = word_count != '0 ? FETCH : DONE;
            FETCH:   state_n = LOAD;
            LOAD:    state_n = SHIFT;
            SHIFT:   if (take) state_n = refill ? SHIFT : rem != '0 ? MORE : cnt_sh != '0 ? FLUSH : DONE;
            FLUSH:   if (fire) state_n = DONE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            bits <= '0;
            cnt <= '0;
            addr <= '0;
            rem <= '0;
`ifdef MEM_TO_DRAM_PREFETCH_EN
            hold <= '0;
            full <= 1'b0;
            pend <= 1'b0;
`endif
        end else begin
            state <= state_n;
            if (state == IDLE && start) begin
                bits <= '0;
                cnt <= '0;
                addr <= base_addr;
                rem <= word_count;
            end
            if (bram_rd_en) begin
                addr <= addr + ADDR_W'(1);
                rem <= rem - (ADDR_W + 1)'(1);
            end
            if (state == LOAD) begin
                bits <= bits | place(bram_rd_data, cnt);
                cnt <= cnt + CNT_W'(WORD_W);
            end
            if (fire) begin
                bits <= shifted;
                cnt <= state == FLUSH ? '0 : cnt_sh;
            end
`ifdef MEM_TO_DRAM_PREFETCH_EN
            pend <= issue;
            if (take && refill) begin
                bits <= shifted | place(full ? hold : bram_rd_data, cnt_sh);
                cnt <= cnt_sh + CNT_W'(WORD_W);
            end
            if (state == SHIFT && pend && !take) begin
                hold <= bram_rd_data;
                full <= 1'b1;
            end else if (take && full) begin
                full <= 1'b0;
            end
`endif
        end
    end
endmodule

// File: tb/tb_memory_to_dram.sv
// tb_memory_to_dram: directed self-checking bench for memory_to_dram
module tb_memory_to_dram;
    logic clk = 0, rst = 1, start = 0, dout_ready = 1;
    logic [7:0] base_addr = 0;
    logic [8:0] word_count = 0;
    logic bram_rd_en, dout_valid, busy, done;
    logic [7:0] bram_addr, dout_data;
    logic [162:0] bram_rd_data;
    logic [162:0] mem [256];
    logic [7:0] got[$], reads[$], exp_q[$];
    int accq[$], vq[$], dq[$];
    int cyc = 0, busy_cnt = 0, passed = 0, failed = 0, total = 0;
`ifdef MEM_TO_DRAM_PREFETCH_EN
    localparam int SPAN = 82;
`else
    localparam int SPAN = 88;
`endif

    always #5 clk = ~clk;

    memory_to_dram dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
        .bram_rd_en(bram_rd_en), .bram_addr(bram_addr), .bram_rd_data(bram_rd_data),
        .dout_data(dout_data), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .busy(busy), .done(done)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bram_rd_en) bram_rd_data <= mem[bram_addr];
        if (!rst) begin
            if (bram_rd_en) reads.push_back(bram_addr);
            if (dout_valid) vq.push_back(cyc);
            if (dout_valid && dout_ready) begin
                got.push_back(dout_data);
                accq.push_back(cyc);
            end
            if (done) dq.push_back(cyc);
            if (busy) busy_cnt <= busy_cnt + 1;
        end
    end

    task automatic chk(input string tag, input longint obs, input longint expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic rst_chk(input string tag);
        chk({tag, "_rd_en"}, bram_rd_en, 0);
        chk({tag, "_addr"}, bram_addr, 0);
        chk({tag, "_data"}, dout_data, 0);
        chk({tag, "_valid"}, dout_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    task automatic kick(input logic [7:0] b, input logic [8:0] n);
        @(negedge clk);
        base_addr = b;
        word_count = n;
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic wait_done(input string tag, input int d0);
        int i = 0;
        while (dq.size() == d0 && i < 5000) begin
            @(negedge clk);
            i++;
        end
        chk({tag, "_done"}, dq.size() - d0, 1);
    endtask

    task automatic wait_bytes(input string tag, input int n);
        int i = 0;
        while (got.size() < n && i < 5000) begin
            @(negedge clk);
            i++;
        end
        chk({tag, "_reach"}, got.size(), n);
    endtask

    // Reference packing: walk every bit of every word in order, emitting a byte per 8 bits.
    task automatic build(input logic [7:0] b, input int n);
        logic [7:0] acc = 0;
        int k = 0;
        exp_q.delete();
        for (int w = 0; w < n; w++)
            for (int i = 162; i >= 0; i--) begin
                acc = {acc[6:0], mem[8'(b + w)][i]};
                k++;
                if (k == 8) begin
                    exp_q.push_back(acc);
                    k = 0;
                end
            end
        if (k > 0) exp_q.push_back(acc << (8 - k));
    endtask

    task automatic cmp(input string tag, input int s);
        int bad = 0;
        chk({tag, "_len"}, got.size() - s, exp_q.size());
        for (int i = 0; i < exp_q.size() && s + i < got.size(); i++)
            if (got[s + i] !== exp_q[i]) bad++;
        chk({tag, "_bytes"}, bad, 0);
    endtask

    initial begin
        int s, r, d, v, b, bad;
        logic [7:0] hd;
        for (int i = 0; i < 256; i++)
            mem[i] = 163'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
        repeat (3) @(negedge clk);
        rst_chk("reset");
        rst = 0;

        // single all-ones word: 20 x FF then E0, with exact launch latency
        mem[8'h10] = '1;
        s = got.size(); r = reads.size(); d = dq.size();
        kick(8'h10, 1);
        chk("t1_rd_en", bram_rd_en, 1);
        chk("t1_rd_addr", bram_addr, 8'h10);
        @(negedge clk);
        chk("t1_valid_early", dout_valid, 0);
        @(negedge clk);
        chk("t1_valid_t3", dout_valid, 1);
        wait_done("t1", d);
        chk("t1_len", got.size() - s, 21);
        chk("t1_b0", got[s], 8'hFF);
        chk("t1_b19", got[s + 19], 8'hFF);
        chk("t1_b20", got[s + 20], 8'hE0);
        chk("t1_nreads", reads.size() - r, 1);
        chk("t1_read_addr", reads[r], 8'h10);
        chk("t1_done_lat", dq[$] - accq[$], 1);
        @(negedge clk);
        chk("t1_busy_after", busy, 0);

        // ones then zeros: straddling byte holds 3 ones then 5 zeros
        mem[0] = '1; mem[1] = '0;
        s = got.size(); d = dq.size();
        kick(8'h00, 2);
        wait_done("t2", d);
        chk("t2_len", got.size() - s, 41);
        chk("t2_b19", got[s + 19], 8'hFF);
        chk("t2_b20", got[s + 20], 8'hE0);
        chk("t2_b40", got[s + 40], 8'h00);
        build(8'h00, 2);
        cmp("t2", s);

        // eight words align exactly: 163 bytes, no pad byte
        s = got.size(); d = dq.size();
        kick(8'h20, 8);
        wait_done("t3", d);
        chk("t3_len163", got.size() - s, 163);
        build(8'h20, 8);
        cmp("t3", s);

        // backpressure at byte 3 for 5 cycles
        s = got.size(); d = dq.size();
        kick(8'h40, 2);
        wait_bytes("t4", s + 3);
        dout_ready = 0;
        hd = dout_data;
        chk("t4_valid_held", dout_valid, 1);
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (dout_data !== hd || dout_valid !== 1'b1) bad++;
        end
        chk("t4_stable", bad, 0);
        chk("t4_no_accept", got.size() - s, 3);
        dout_ready = 1;
        wait_done("t4", d);
        build(8'h40, 2);
        cmp("t4", s);

        // address wrap, and a start while busy that must be ignored
        s = got.size(); r = reads.size(); d = dq.size();
        kick(8'hFE, 3);
        repeat (4) @(negedge clk);
        base_addr = 8'h55; word_count = 1; start = 1;
        @(negedge clk);
        start = 0;
        wait_done("t5", d);
        chk("t5_nreads", reads.size() - r, 3);
        chk("t5_rd0", reads[r], 8'hFE);
        chk("t5_rd1", reads[r + 1], 8'hFF);
        chk("t5_rd2", reads[r + 2], 8'h00);
        build(8'hFE, 3);
        cmp("t5", s);
        repeat (5) @(negedge clk);
        chk("t5_single_done", dq.size() - d, 1);

        // zero-length transfer
        r = reads.size(); v = vq.size(); d = dq.size(); b = busy_cnt;
        kick(8'h30, 0);
        wait_done("t6", d);
        chk("t6_no_reads", reads.size() - r, 0);
        chk("t6_no_valid", vq.size() - v, 0);
        chk("t6_no_busy", busy_cnt - b, 0);

        // reset in the middle of a transfer, then a clean restart
        s = got.size(); d = dq.size();
        kick(8'h60, 4);
        wait_bytes("t7", s + 10);
        rst = 1;
        @(negedge clk);
        rst_chk("t7_abort");
        repeat (3) @(negedge clk);
        chk("t7_no_done", dq.size() - d, 0);
        rst = 0;
        s = got.size(); d = dq.size();
        kick(8'h70, 2);
        wait_done("t7", d);
        build(8'h70, 2);
        cmp("t7", s);

        // four words with ready high: 82 bytes over SPAN cycles
        s = got.size(); v = vq.size(); d = dq.size();
        kick(8'h80, 4);
        wait_done("t8", d);
        chk("t8_valid_cycles", vq.size() - v, 82);
        chk("t8_span", vq[$] - vq[v] + 1, SPAN);
        build(8'h80, 4);
        cmp("t8", s);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
